// File: rtl/sbox_word_pipe.sv
// sbox_word_pipe
//   Pipelined AES S-box over a word of LANES independent byte lanes.
//   Each lane inverts in GF(2^8) through the composite field GF(((2^2)^2)^2):
//   x^2+x+phi over GF(2^2) with phi = {10}, and y^2+y+lambda over GF(2^4) with
//   lambda = {1100}. The forward/inverse choice is per word and travels with it.
//
//   Pipeline:
//     S1  optional inverse affine, isomorphic map, d = ah^2*lambda ^ ah*al ^ al^2
//     S2  d_inv = gf4_inv(d)
//     S3  h = ah*d_inv, l = (ah^al)*d_inv, inverse map, optional forward affine
//   All stages advance together when en = ~v3 | out_ready and hold otherwise.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   input accepted this cycle when high (combinational from out_ready)
//   in_inv     0 = forward S-box, 1 = inverse S-box
//   in_data    input bytes, lane k = in_data[8k+7:8k]
//   out_valid  output word valid
//   out_ready  downstream accepts output
//   out_data   substituted bytes, same lane order
//   busy       any stage holds a valid word
module sbox_word_pipe #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 busy
);

    localparam int W = 8 * LANES;

    // GF(2^2) multiply, basis {x, 1} modulo x^2+x+1
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] k;
        k[1] = (a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
        k[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
        return k;
    endfunction

    // multiply by phi = {10}
    function automatic logic [1:0] gf2_mul_phi(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] q, input logic [3:0] w);
        logic [1:0] hh, hl, lh, ll;
        hh = gf2_mul(q[3:2], w[3:2]);
        hl = gf2_mul(q[3:2], w[1:0]);
        lh = gf2_mul(q[1:0], w[3:2]);
        ll = gf2_mul(q[1:0], w[1:0]);
        return {hh ^ hl ^ lh, gf2_mul_phi(hh) ^ ll};
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
    endfunction

    // multiply by lambda = {1100}
    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] q);
        return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
    endfunction

    // GF(2^4) inverse; maps 0 to 0, which is what makes S(0x00)=0x63 fall out
    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic [3:0] r;
        r[3] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[0]) ^ q[2];
        r[2] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[0])
             ^ q[2] ^ (q[2] & q[1]);
        r[1] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[1] & q[0]) ^ q[2]
             ^ (q[2] & q[0]) ^ q[1];
        r[0] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[1])
             ^ (q[3] & q[1] & q[0]) ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1])
             ^ (q[2] & q[1] & q[0]) ^ q[1] ^ q[0];
        return r;
    endfunction

    // polynomial basis GF(2^8) -> composite basis {ah, al}
    function automatic logic [7:0] iso_map(input logic [7:0] x);
        logic [7:0] q;
        q[7] = x[7] ^ x[5];
        q[6] = x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
        q[5] = x[7] ^ x[5] ^ x[3] ^ x[2];
        q[4] = x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1];
        q[3] = x[7] ^ x[6] ^ x[2] ^ x[1];
        q[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
        q[1] = x[6] ^ x[4] ^ x[1];
        q[0] = x[6] ^ x[1] ^ x[0];
        return q;
    endfunction

    function automatic logic [7:0] iso_inv_map(input logic [7:0] q);
        logic [7:0] y;
        y[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
        y[6] = q[6] ^ q[2];
        y[5] = q[6] ^ q[5] ^ q[1];
        y[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
        y[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        y[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        y[1] = q[5] ^ q[4];
        y[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
        return y;
    endfunction

    // returns {ah, al, d}
    function automatic logic [11:0] s1_front(input logic [7:0] b_in, input logic inv);
        logic [7:0] b;
        logic [7:0] q;
        logic [3:0] d;
        if (inv) begin
            b = {b_in[6:0], b_in[7]} ^ {b_in[4:0], b_in[7:5]} ^ {b_in[1:0], b_in[7:2]} ^ 8'h05;
        end else begin
            b = b_in;
        end
        q = iso_map(b);
        d = gf4_mul_lambda(gf4_sq(q[7:4])) ^ gf4_mul(q[7:4], q[3:0]) ^ gf4_sq(q[3:0]);
        return {q, d};
    endfunction

    function automatic logic [7:0] s3_back(input logic [3:0] ah, input logic [3:0] al,
                                           input logic [3:0] dinv, input logic inv);
        logic [7:0] y;
        y = iso_inv_map({gf4_mul(ah, dinv), gf4_mul(ah ^ al, dinv)});
        if (!inv) begin
            y = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                  ^ {y[3:0], y[7:4]} ^ 8'h63;
        end
        return y;
    endfunction

    logic                   w_en;
    logic                   r_v1, r_v2, r_v3;
    logic                   r_inv1, r_inv2;
    logic [LANES-1:0][3:0]  r_s1_ah, r_s1_al, r_s1_d;
    logic [LANES-1:0][3:0]  r_s2_ah, r_s2_al, r_s2_dinv;
    logic [W-1:0]           r_out;

    logic [LANES-1:0][3:0]  w_s1_ah, w_s1_al, w_s1_d;
    logic [LANES-1:0][3:0]  w_s2_dinv;
    logic [W-1:0]           w_s3_byte;

    assign w_en = ~r_v3 | out_ready;

    always_comb begin
        w_s1_ah   = '0;
        w_s1_al   = '0;
        w_s1_d    = '0;
        w_s2_dinv = '0;
        w_s3_byte = '0;
        for (int k = 0; k < LANES; k++) begin
            {w_s1_ah[k], w_s1_al[k], w_s1_d[k]} = s1_front(in_data[8*k +: 8], in_inv);
            w_s2_dinv[k] = gf4_inv(r_s1_d[k]);
            w_s3_byte[8*k +: 8] = s3_back(r_s2_ah[k], r_s2_al[k], r_s2_dinv[k], r_inv2);
        end
    end

    // Data registers load on every enabled edge, bubbles included; only the
    // valid bits decide whether a stage's contents mean anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_inv1    <= 1'b0;
            r_inv2    <= 1'b0;
            r_s1_ah   <= '0;
            r_s1_al   <= '0;
            r_s1_d    <= '0;
            r_s2_ah   <= '0;
            r_s2_al   <= '0;
            r_s2_dinv <= '0;
            r_out     <= '0;
        end else if (w_en) begin
            r_v1      <= in_valid;
            r_v2      <= r_v1;
            r_v3      <= r_v2;
            r_inv1    <= in_inv;
            r_inv2    <= r_inv1;
            r_s1_ah   <= w_s1_ah;
            r_s1_al   <= w_s1_al;
            r_s1_d    <= w_s1_d;
            r_s2_ah   <= r_s1_ah;
            r_s2_al   <= r_s1_al;
            r_s2_dinv <= w_s2_dinv;
            r_out     <= w_s3_byte;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_v3;
    assign out_data  = r_out;
    assign busy      = r_v1 | r_v2 | r_v3;

endmodule

// File: tb/tb_sbox_word_pipe.sv
module tb_sbox_word_pipe;

    localparam int LANES = 4;
    localparam int W     = 8 * LANES;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_inv    = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [W-1:0]  out_data;

    sbox_word_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [W-1:0] exp_q [$];
    int           emit_cycles [$];
    logic [W-1:0] last_out = '0;
    bit           rnd_ready = 1'b0;

    // Reference model: plain GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] iv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = inv ? inv_tab[w[8*k +: 8]] : fwd_tab[w[8*k +: 8]];
        return r;
    endfunction

    // Monitor/scoreboard: at the falling edge, the handshakes visible now are
    // exactly the ones the next rising edge will perform.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (out_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got %h, expected no output", out_data);
                end else if (out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL out_data: got %h, expected %h", out_data, exp_q[0]);
                end
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    last_out = out_data;
                    emit_cycles.push_back(cyc);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model_word(in_data, in_inv));
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives a word and returns at posedge+1 after the edge that accepted it.
    task automatic send(input logic [W-1:0] d, input logic inv);
        bit done;
        int k;
        done = 1'b0;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (!done && k < 1000) begin
            @(negedge clk);
            done = in_ready;
            k++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no accept, expected accept of %h", d);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        int gap;
        build_tables();

        // reset state
        #12;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_out_data", out_data, '0);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // zero word, latency
        send(32'h0000_0000, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("latency_c%0d", i + 1), W'(out_valid), W'(i == 2));
        end
        drain();
        chk("zero_fwd", last_out, 32'h6363_6363);

        // key expansion SubWord
        send(32'hCF4F_3C09, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("subword_w4", last_out, 32'h8A84_EB01);

        // spot checks
        send(32'h53FF_5353, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("spot_fwd", last_out, 32'hED16_EDED);
        send(32'hED63_EDED, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("spot_inv", last_out, 32'h5300_5353);

        // exhaustive, both modes
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 64; i++)
                send({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'(m));
        in_valid = 1'b0;
        drain();

        // back-to-back alternating modes
        emit_cycles.delete();
        for (int i = 0; i < 10; i++) send($urandom, 1'(i % 2));
        in_valid = 1'b0;
        drain();
        chk("b2b_count", W'(emit_cycles.size()), W'(10));
        if (emit_cycles.size() == 10)
            chk("b2b_span", W'(emit_cycles[9] - emit_cycles[0]), W'(9));

        // backpressure with 3 in flight
        for (int i = 0; i < 3; i++) send($urandom, 1'(i == 1));
        out_ready = 1'b0;
        w = $urandom;
        in_valid = 1'b1;
        in_data  = w;
        in_inv   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_out_valid", W'(out_valid), W'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(w, 1'b1);
        in_valid = 1'b0;
        drain();

        // asynchronous reset with 2 in flight
        send($urandom, 1'b0);
        send($urandom, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", W'(busy), W'(0));
        @(posedge clk);
        #1;

        // random traffic with random backpressure
        rnd_ready = 1'b1;
        fork
            begin
                while (rnd_ready) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            send($urandom, 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
